// File: rtl/dvp_capture_pkg.sv
// Shared types and constants for the DVP camera capture block.
// Top-level build option: DVP_CAPTURE_STATS_EN adds line-error / line-count statistics.
package dvp_capture_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_SOF = 2'd1,
      ST_ACTIVE   = 2'd2
   } state_t;

   localparam logic [1:0] MODE_YUV = 2'd0;
   localparam logic [1:0] MODE_RGB = 2'd1;
   localparam logic [1:0] MODE_RAW = 2'd2;

endpackage

// File: rtl/dvp_byte_pack.sv
// Pairs camera bytes into pixels, registers the packed pixel with a one-cycle
// strobe and tracks the in-line pixel index (saturating).
module dvp_byte_pack
   import dvp_capture_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int X_W    = 11
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic [DATA_W-1:0]   data,
   input  logic [1:0]          mode,
   output logic [2*DATA_W-1:0] pix,
   output logic                dval,
   output logic [X_W-1:0]      x
);

   localparam logic [X_W-1:0] X_ONE = X_W'(1);
   localparam logic [X_W-1:0] X_MAX = '1;

   logic                phase_q, phase_d;
   logic [DATA_W-1:0]   byte0_q, byte0_d;
   logic [X_W-1:0]      cnt_q, cnt_d;
   logic [2*DATA_W-1:0] pix_q, pix_d;
   logic                dval_q, dval_d;
   logic [X_W-1:0]      x_q, x_d;
   logic [X_W-1:0]      cnt_inc;

   assign cnt_inc = (cnt_q == X_MAX) ? cnt_q : cnt_q + X_ONE;

   always_comb begin
      phase_d = 1'b0;
      byte0_d = byte0_q;
      cnt_d   = cnt_q;
      pix_d   = pix_q;
      dval_d  = 1'b0;
      x_d     = x_q;
      if (!en) begin
         cnt_d = '0;
      end else if (mode == MODE_RAW) begin
         dval_d = 1'b1;
         pix_d  = {{DATA_W{1'b0}}, data};
         x_d    = cnt_q;
         cnt_d  = cnt_inc;
      end else if (!phase_q) begin
         phase_d = 1'b1;
         byte0_d = data;
      end else begin
         dval_d = 1'b1;
         x_d    = cnt_q;
         cnt_d  = cnt_inc;
         // RGB565 arrives high byte first; YUV422 (and the spare mode) low byte first
         pix_d  = (mode == MODE_RGB) ? {byte0_q, data} : {data, byte0_q};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= 1'b0;
         byte0_q <= '0;
         cnt_q   <= '0;
         pix_q   <= '0;
         dval_q  <= 1'b0;
         x_q     <= '0;
      end else begin
         phase_q <= phase_d;
         byte0_q <= byte0_d;
         cnt_q   <= cnt_d;
         pix_q   <= pix_d;
         dval_q  <= dval_d;
         x_q     <= x_d;
      end
   end

   assign pix  = pix_q;
   assign dval = dval_q;
   assign x    = x_q;

endmodule

// File: rtl/dvp_capture.sv
// DVP camera frame capture: frame/line sequencing, line checks and frame counting.
// Define DVP_CAPTURE_STATS_EN to add oERR_CNT and oLINES_LAST statistics outputs.
//
// state       | meaning
// ST_IDLE     | not armed, inputs ignored
// ST_WAIT_SOF | armed, waiting for VSYNC falling edge
// ST_ACTIVE   | inside a frame, bytes are captured while HREF is high
module dvp_capture
   import dvp_capture_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int LINE_BYTES = 1280,
   parameter int X_W        = 11,
   parameter int Y_W        = 10,
   parameter int FRM_W      = 32
) (
   input  logic                iCLK,
   input  logic                iRST,
   input  logic [DATA_W-1:0]   iDATA,
   input  logic                iVSYNC,
   input  logic                iHREF,
   input  logic                iSTART,
   input  logic                iEND,
   input  logic [1:0]          iMODE,
   output logic [2*DATA_W-1:0] oPIX,
   output logic                oDVAL,
   output logic [X_W-1:0]      oX,
   output logic [Y_W-1:0]      oY,
   output logic [FRM_W-1:0]    oFRAME_CNT,
   output logic                oSOF,
   output logic                oEOF,
   output logic                oLINE_ERR,
   output logic                oBUSY
`ifdef DVP_CAPTURE_STATS_EN
   ,
   output logic [15:0]         oERR_CNT,
   output logic [Y_W-1:0]      oLINES_LAST
`endif
);

   localparam int             BC_W   = $clog2(LINE_BYTES + 1) + 1;
   localparam logic [BC_W-1:0] BC_MAX = '1;

   state_t            state_q, state_d;
   logic              stop_q, stop_d;
   logic              vsync_q, vsync_d;
   logic              href_q, href_d;
   logic [1:0]        mode_q, mode_d;
   logic              sof_q, sof_d;
   logic              eof_q, eof_d;
   logic              err_q, err_d;
   logic [Y_W-1:0]    y_q, y_d;
   logic [FRM_W-1:0]  frm_q, frm_d;
   logic [BC_W-1:0]   bcnt_q, bcnt_d;

   logic active, vs_fall, vs_rise, href_fall, pack_en;

   assign active    = (state_q == ST_ACTIVE);
   assign vs_fall   = vsync_q & ~iVSYNC;
   assign vs_rise   = ~vsync_q & iVSYNC;
   assign href_fall = href_q & ~iHREF;
   // A byte arriving on the VSYNC rise belongs to an abandoned line
   assign pack_en   = active & iHREF & ~vs_rise;

   always_comb begin
      state_d = state_q;
      stop_d  = stop_q | iEND;
      vsync_d = iVSYNC;
      href_d  = iHREF;
      mode_d  = mode_q;
      sof_d   = 1'b0;
      eof_d   = 1'b0;
      err_d   = 1'b0;
      y_d     = y_q;
      frm_d   = frm_q;
      bcnt_d  = '0;
      if (pack_en) begin
         bcnt_d = (bcnt_q == BC_MAX) ? bcnt_q : bcnt_q + BC_W'(1);
      end
      case (state_q)
         ST_IDLE: begin
            if (iSTART && !iEND) begin
               state_d = ST_WAIT_SOF;
               stop_d  = 1'b0;
            end
         end
         ST_WAIT_SOF: begin
            if (vs_fall) begin
               state_d = ST_ACTIVE;
               sof_d   = 1'b1;
               mode_d  = iMODE;
               y_d     = '0;
            end
         end
         ST_ACTIVE: begin
            if (href_fall) begin
               if (bcnt_q != '0) y_d = y_q + Y_W'(1);
               if (bcnt_q != BC_W'(LINE_BYTES)) err_d = 1'b1;
            end
            if (vs_rise) begin
               state_d = stop_d ? ST_IDLE : ST_WAIT_SOF;
               if (!iHREF) begin
                  eof_d = 1'b1;
                  frm_d = frm_q + FRM_W'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (state_q != ST_IDLE && state_d == ST_IDLE) stop_d = 1'b0;
   end

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         state_q <= ST_IDLE;
         stop_q  <= 1'b0;
         vsync_q <= 1'b0;
         href_q  <= 1'b0;
         mode_q  <= MODE_YUV;
         sof_q   <= 1'b0;
         eof_q   <= 1'b0;
         err_q   <= 1'b0;
         y_q     <= '0;
         frm_q   <= '0;
         bcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         stop_q  <= stop_d;
         vsync_q <= vsync_d;
         href_q  <= href_d;
         mode_q  <= mode_d;
         sof_q   <= sof_d;
         eof_q   <= eof_d;
         err_q   <= err_d;
         y_q     <= y_d;
         frm_q   <= frm_d;
         bcnt_q  <= bcnt_d;
      end
   end

   dvp_byte_pack #(
      .DATA_W (DATA_W),
      .X_W    (X_W)
   ) u_pack (
      .clk   (iCLK),
      .rst_n (iRST),
      .en    (pack_en),
      .data  (iDATA),
      .mode  (mode_q),
      .pix   (oPIX),
      .dval  (oDVAL),
      .x     (oX)
   );

   assign oY         = y_q;
   assign oFRAME_CNT = frm_q;
   assign oSOF       = sof_q;
   assign oEOF       = eof_q;
   assign oLINE_ERR  = err_q;
   assign oBUSY      = (state_q != ST_IDLE);

`ifdef DVP_CAPTURE_STATS_EN
   logic [15:0]    errcnt_q, errcnt_d;
   logic [Y_W-1:0] lines_q, lines_d;

   always_comb begin
      errcnt_d = errcnt_q;
      lines_d  = lines_q;
      if (iSTART) begin
         errcnt_d = '0;
      end else if (err_d && errcnt_q != 16'hFFFF) begin
         errcnt_d = errcnt_q + 16'd1;
      end
      if (eof_d) lines_d = y_d;
   end

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         errcnt_q <= '0;
         lines_q  <= '0;
      end else begin
         errcnt_q <= errcnt_d;
         lines_q  <= lines_d;
      end
   end

   assign oERR_CNT    = errcnt_q;
   assign oLINES_LAST = lines_q;
`endif

endmodule
